// File: rtl/acc_tx_pkg.sv
// Shared constants and types for the accumulator serial transmitter.
// Frame = start bit, WORD_WIDTH data bits LSB first, stop bit.
package acc_tx_pkg;
  localparam int WORD_WIDTH = 11;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int FRAME_BITS = WORD_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;
endpackage

// File: rtl/acc_tx_if.sv
// Write port and status bundle of the serial transmitter.
// master = word producer, slave = transmitter.
import acc_tx_pkg::*;

interface acc_tx_if #(
  parameter int WORD_WIDTH = acc_tx_pkg::WORD_WIDTH,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [WORD_WIDTH-1:0] tx_in;
  logic                  tx_wr;
  logic                  tx_serial;
  logic                  tx_busy;
  logic                  tx_full;
  logic                  tx_empty;
  logic [CW-1:0]         tx_count;
  logic                  tx_overflow;

  modport master (
    output tx_in, tx_wr,
    input  tx_serial, tx_busy, tx_full,
    input  tx_empty, tx_count, tx_overflow
  );

  modport slave (
    input  tx_in, tx_wr,
    output tx_serial, tx_busy, tx_full,
    output tx_empty, tx_count, tx_overflow
  );
endinterface

// File: rtl/acc_tx_fifo.sv
// Synchronous word FIFO; full/empty come from the occupancy count.
// Reset flushes pointers and count, storage is left as is.
import acc_tx_pkg::*;

module acc_tx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       tx_reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;

  assign full = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout = mem[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (tx_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!tx_reset && do_push) mem[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/acc_serial_tx.sv
// Buffers accumulator OUT words and shifts them out as framed serial words.
// Writes never stall; a write into a full FIFO is dropped and flagged.
import acc_tx_pkg::*;

module acc_serial_tx #(
  parameter int WORD_WIDTH = acc_tx_pkg::WORD_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input logic   clock,
  input logic   tx_reset,
  acc_tx_if.slave bus
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(WORD_WIDTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic serial_q, serial_d;
  logic busy_q, busy_d;
  logic ovf_q, ovf_d;

  logic pop;
  logic baud_end;
  logic fifo_full, fifo_empty;
  logic [WORD_WIDTH-1:0] fifo_dout;
  logic [CW-1:0] fifo_count;

  acc_tx_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .tx_reset (tx_reset),
    .push     (bus.tx_wr),
    .pop      (pop),
    .din      (bus.tx_in),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign baud_end = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d = baud_end ? '0 : baud_q + BW'(1);
    idx_d = idx_q;
    shift_d = shift_q;
    serial_d = serial_q;
    busy_d = busy_q;
    pop = 1'b0;
    // a write into a full FIFO is lost even when a pop frees a slot
    ovf_d = ovf_q | (bus.tx_wr & fifo_full);
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
          serial_d = START_BIT;
          busy_d = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          idx_d = '0;
          serial_d = shift_q[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (idx_q == IW'(WORD_WIDTH - 1)) begin
            state_d = STOP;
            serial_d = STOP_BIT;
          end else begin
            shift_d = shift_q >> 1;
            idx_d = idx_q + IW'(1);
            serial_d = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          if (!fifo_empty) begin
            pop = 1'b1;
            shift_d = fifo_dout;
            state_d = START;
            serial_d = START_BIT;
          end else begin
            state_d = IDLE;
            serial_d = IDLE_LEVEL;
            busy_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (tx_reset) begin
      state_q <= IDLE;
      baud_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      serial_q <= IDLE_LEVEL;
      busy_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      serial_q <= serial_d;
      busy_q <= busy_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.tx_serial = serial_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_full = fifo_full;
  assign bus.tx_empty = fifo_empty;
  assign bus.tx_count = fifo_count;
  assign bus.tx_overflow = ovf_q;
endmodule
